// File: rtl/clause_resweep_ctrl_if.sv
// Clause RAM port bundle for clause_resweep_ctrl.
//   master : sweep controller side (drives read/write strobes, address, write data)
//   slave  : clause RAM side (returns rd_data one cycle after rd_en)
interface clause_resweep_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int ENTRY_W = 32
);
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/clause_resweep_ctrl.sv
// clause_resweep_ctrl: post-backtrack clause sweep engine.
// Reads every clause RAM entry once, passes it through the external
// combinational re_update stage, registers the result and writes it back to
// the same address. Counts valid clauses left active and flags a conflict
// (valid, active, no unassigned literal left).
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, abort     sweep request (ignored while busy/done), synchronous cancel
//   busy, done       sweep in progress, 1-cycle completion pulse
//   active_cnt       valid clauses with ru_active_out=1 (saturates at NUM_CLAUSES)
//   conflict         sticky per sweep
//   ram              clause RAM bus (clause_resweep_ctrl_if.master)
//   ru_*_in/ru_*_out fields to / results from re_update
//
// Build option CLAUSE_RESWEEP_SKIP_INVALID_EN: when defined, write-back of
// entries whose re_update result has valid=0 is suppressed (slot stays idle).
module clause_resweep_ctrl #(
  parameter int WIDTH       = 9,
  parameter int NUM_CLAUSES = 256,
  parameter int ADDR_W      = $clog2(NUM_CLAUSES),
  parameter int ENTRY_W     = 3*WIDTH+5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      active_cnt,
  output logic                 conflict,
  clause_resweep_ctrl_if.master ram,
  output logic [2:0]           ru_clause_in,
  output logic [3*WIDTH-1:0]   ru_cnf_in,
  output logic                 ru_active_in,
  output logic                 ru_valid_in,
  input  logic [2:0]           ru_clause_out,
  input  logic [3*WIDTH-1:0]   ru_cnf_out,
  input  logic                 ru_active_out,
  input  logic                 ru_valid_out
);
  // Pipeline: [0] read issued, [1] rd_data at re_update, [2] write slot
  localparam int STAGES = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_CLAUSES-1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(NUM_CLAUSES);

  logic [1:0]         state;
  logic [STAGES:0]    vld_pipe;
  logic [ADDR_W-1:0]  rd_addr_q, addr_d1, wr_addr_q;
  logic [ENTRY_W-1:0] wr_data_q;
  logic               wr_en_q;
  logic               hit;

  assign ram.rd_en   = vld_pipe[0];
  assign ram.rd_addr = rd_addr_q;
  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;

  assign busy = (state == S_READ) || (state == S_DRAIN);

  // RAM word {valid, active, clause[2:0], lits}
  assign ru_valid_in  = ram.rd_data[ENTRY_W-1];
  assign ru_active_in = ram.rd_data[ENTRY_W-2];
  assign ru_clause_in = ram.rd_data[ENTRY_W-3 -: 3];
  assign ru_cnf_in    = ram.rd_data[3*WIDTH-1:0];

  assign hit = ru_valid_out && ru_active_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vld_pipe   <= '0;
      rd_addr_q  <= '0;
      addr_d1    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done       <= 1'b0;
      active_cnt <= '0;
      conflict   <= 1'b0;
    end else if (abort) begin
      // In-flight read/write discarded; counters keep their current value.
      state    <= S_IDLE;
      vld_pipe <= '0;
      wr_en_q  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done                  <= 1'b0;
      vld_pipe[STAGES:1]    <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) addr_d1 <= rd_addr_q;
      if (vld_pipe[1]) begin
        wr_addr_q <= addr_d1;
        wr_data_q <= {ru_valid_out, ru_active_out, ru_clause_out, ru_cnf_out};
        if (hit && active_cnt != CNT_MAX) active_cnt <= active_cnt + (ADDR_W+1)'(1);
        if (hit && ru_clause_out == 3'b000) conflict <= 1'b1;
      end
`ifdef CLAUSE_RESWEEP_SKIP_INVALID_EN
      wr_en_q <= vld_pipe[1] && ru_valid_out;
`else
      wr_en_q <= vld_pipe[1];
`endif
      case (state)
        S_IDLE: if (start) begin
          state       <= S_READ;
          vld_pipe[0] <= 1'b1;
          rd_addr_q   <= '0;
          active_cnt  <= '0;
          conflict    <= 1'b0;
        end
        S_READ: if (rd_addr_q == LAST) begin
          state       <= S_DRAIN;
          vld_pipe[0] <= 1'b0;
        end else begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        // Write slot tracked by vld_pipe so skipped writes still close the sweep.
        S_DRAIN: if (vld_pipe[STAGES] && wr_addr_q == LAST) begin
          state <= S_FIN;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clause_resweep_ctrl.sv
module tb_clause_resweep_ctrl;
  localparam int WIDTH = 9;
  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int EW    = 3*WIDTH+5;
  localparam int TR    = 10;
`ifdef CLAUSE_RESWEEP_SKIP_INVALID_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, conflict;
  logic [AW:0] active_cnt;
  logic [2:0] ru_clause_in, ru_clause_out;
  logic [3*WIDTH-1:0] ru_cnf_in, ru_cnf_out;
  logic ru_active_in, ru_valid_in, ru_active_out, ru_valid_out;

  always #5 clk = ~clk;

  clause_resweep_ctrl_if #(.ADDR_W(AW), .ENTRY_W(EW)) ram ();

  clause_resweep_ctrl #(.WIDTH(WIDTH), .NUM_CLAUSES(N), .ADDR_W(AW), .ENTRY_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .active_cnt(active_cnt), .conflict(conflict),
    .ram(ram),
    .ru_clause_in(ru_clause_in), .ru_cnf_in(ru_cnf_in), .ru_active_in(ru_active_in),
    .ru_valid_in(ru_valid_in), .ru_clause_out(ru_clause_out), .ru_cnf_out(ru_cnf_out),
    .ru_active_out(ru_active_out), .ru_valid_out(ru_valid_out)
  );

  // Clause RAM: one-cycle read latency
  logic [EW-1:0] mem [N];
  always @(posedge clk) if (ram.rd_en) ram.rd_data <= mem[ram.rd_addr];

  // Toy re_update: a true literal retires the clause (active=0, clause=000);
  // otherwise clause bit i = literal i still unassigned. Invalid entries pass through.
  logic [7:0] lit_asg, lit_val;
  logic sat;
  logic [2:0] cl;
  logic [WIDTH-1:0] lit;
  always_comb begin
    ru_valid_out  = ru_valid_in;
    ru_active_out = ru_active_in;
    ru_clause_out = ru_clause_in;
    ru_cnf_out    = ru_cnf_in;
    sat = 1'b0;
    cl  = 3'b000;
    lit = '0;
    if (ru_valid_in) begin
      for (int i = 0; i < 3; i++) begin
        lit = ru_cnf_in[i*WIDTH +: WIDTH];
        if (lit_asg[lit[2:0]]) begin
          if (lit_val[lit[2:0]] ^ lit[WIDTH-1]) sat = 1'b1;
        end else cl[i] = 1'b1;
      end
      if (sat) begin
        ru_active_out = 1'b0;
        ru_clause_out = 3'b000;
      end else ru_clause_out = cl;
    end
  end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lt(input bit neg, input int n);
    return {neg, 8'(n)};
  endfunction
  function automatic logic [EW-1:0] mk(input logic v, input logic a, input logic [2:0] c,
                                       input logic [WIDTH-1:0] l0, l1, l2);
    return {v, a, c, l2, l1, l0};
  endfunction

  // Per-cycle trace; cycle 0 is the cycle start is driven
  logic t_rd_en [TR+1], t_wr_en [TR+1], t_busy [TR+1], t_done [TR+1], t_conf [TR+1];
  logic [AW-1:0] t_rd_addr [TR+1], t_wr_addr [TR+1];
  logic [EW-1:0] t_wr_data [TR+1];
  logic [AW:0]   t_cnt [TR+1];
  logic [EW-1:0] exp_wr [N];

  task automatic sweep(input int abort_at, input int restart_at);
    for (int k = 0; k <= TR; k++) begin
      start = (k == 0) || (k == restart_at);
      abort = (k == abort_at);
      @(negedge clk);
      t_rd_en[k] = ram.rd_en;  t_rd_addr[k] = ram.rd_addr;
      t_wr_en[k] = ram.wr_en;  t_wr_addr[k] = ram.wr_addr; t_wr_data[k] = ram.wr_data;
      t_busy[k] = busy; t_done[k] = done; t_cnt[k] = active_cnt; t_conf[k] = conflict;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_full(input string nm, input logic [AW:0] ecnt, input logic econf);
    logic ewe;
    for (int k = 1; k <= TR; k++) begin
      chk($sformatf("%s rd_en@%0d", nm, k), t_rd_en[k], k <= N);
      if (k <= N) chk($sformatf("%s rd_addr@%0d", nm, k), t_rd_addr[k], k-1);
      ewe = (k >= 3 && k <= N+2);
      if (ewe && SKIP && !exp_wr[k-3][EW-1]) ewe = 1'b0;
      chk($sformatf("%s wr_en@%0d", nm, k), t_wr_en[k], ewe);
      if (k >= 3 && k <= N+2) chk($sformatf("%s wr_addr@%0d", nm, k), t_wr_addr[k], k-3);
      if (ewe) chk($sformatf("%s wr_data@%0d", nm, k), t_wr_data[k], exp_wr[k-3]);
      chk($sformatf("%s busy@%0d", nm, k), t_busy[k], k <= N+2);
      chk($sformatf("%s done@%0d", nm, k), t_done[k], k == N+3);
    end
    chk({nm, " active_cnt@done"}, t_cnt[N+3], ecnt);
    chk({nm, " active_cnt@end"}, t_cnt[TR], ecnt);
    chk({nm, " conflict@done"}, t_conf[N+3], econf);
  endtask

  task automatic load_s1();
    lit_asg = 8'h00;
    lit_val = 8'h00;
    for (int i = 0; i < N; i++) begin
      mem[i]    = mk(1'b1, 1'b1, 3'b111, lt(0, 1), lt(0, 2), lt(0, 3));
      exp_wr[i] = mem[i];
    end
  endtask

  initial begin
    lit_asg = 8'h00;
    lit_val = 8'h00;
    #12;
    chk("rst busy", busy, 0);       chk("rst done", done, 0);
    chk("rst rd_en", ram.rd_en, 0); chk("rst wr_en", ram.wr_en, 0);
    chk("rst cnt", active_cnt, 0);  chk("rst conflict", conflict, 0);
    chk("rst rd_addr", ram.rd_addr, 0); chk("rst wr_addr", ram.wr_addr, 0);
    chk("rst wr_data", ram.wr_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All valid, literals unassigned; extra start in the done cycle is ignored
    load_s1();
    sweep(-1, N+3);
    check_full("s1", 3'd4, 1'b0);

    // vars 1,2,3 false: conflict, retired, untouched, invalid passthrough; start while busy ignored
    lit_asg = 8'b0000_1110; lit_val = 8'h00;
    mem[0] = mk(1, 1, 3'b111, lt(0, 1), lt(0, 2), lt(0, 3));
    mem[1] = mk(1, 1, 3'b111, lt(1, 1), lt(0, 2), lt(0, 3));
    mem[2] = mk(1, 1, 3'b111, lt(0, 4), lt(0, 5), lt(0, 6));
    mem[3] = mk(0, 1, 3'b101, lt(0, 1), lt(0, 2), lt(0, 3));
    exp_wr[0] = mk(1, 1, 3'b000, lt(0, 1), lt(0, 2), lt(0, 3));
    exp_wr[1] = mk(1, 0, 3'b000, lt(1, 1), lt(0, 2), lt(0, 3));
    exp_wr[2] = mem[2];
    exp_wr[3] = mem[3];
    sweep(-1, 2);
    check_full("s2", 3'd1 + 3'd1, 1'b1);

    // var1 true: entries 1 and 3 invalid; conflict from previous sweep must clear
    lit_asg = 8'b0000_0010; lit_val = 8'b0000_0010;
    mem[0] = mk(1, 1, 3'b111, lt(0, 1), lt(0, 2), lt(0, 3));
    mem[1] = mk(0, 0, 3'b010, lt(0, 7), lt(0, 7), lt(0, 7));
    mem[2] = mk(1, 1, 3'b111, lt(1, 1), lt(0, 2), lt(0, 3));
    mem[3] = mk(0, 1, 3'b000, lt(0, 1), lt(0, 2), lt(0, 3));
    exp_wr[0] = mk(1, 0, 3'b000, lt(0, 1), lt(0, 2), lt(0, 3));
    exp_wr[1] = mem[1];
    exp_wr[2] = mk(1, 1, 3'b110, lt(1, 1), lt(0, 2), lt(0, 3));
    exp_wr[3] = mem[3];
    sweep(-1, -1);
    check_full("s3", 3'd1, 1'b0);

    // start again in cycle 2, abort in cycle 3: only entry 0 counted, no done
    load_s1();
    sweep(3, 2);
    chk("ab busy@3", t_busy[3], 1);
    chk("ab wr_en@3", t_wr_en[3], 1);
    chk("ab busy@4", t_busy[4], 0);
    chk("ab rd_en@4", t_rd_en[4], 0);
    chk("ab wr_en@4", t_wr_en[4], 0);
    for (int k = 1; k <= TR; k++) chk($sformatf("ab done@%0d", k), t_done[k], 0);
    chk("ab cnt", t_cnt[TR], 1);
    sweep(-1, -1);
    check_full("s4", 3'd4, 1'b0);

    // Reset asserted in cycle 5
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", busy, 1);
    chk("mid cnt", active_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("rst5 busy", busy, 0);       chk("rst5 done", done, 0);
    chk("rst5 rd_en", ram.rd_en, 0); chk("rst5 wr_en", ram.wr_en, 0);
    chk("rst5 cnt", active_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
